// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the adder_arbiter block.
package adder_arb_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/bit_32_adder.sv
// Shared 32-bit combinational adder; carry-out is not exposed.
module bit_32_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// Two-requester arbiter in front of one shared bit_32_adder.
// Optional feature macro: ADDER_ARB_RR_EN selects round-robin arbitration;
// when undefined, requester 0 has fixed priority and no pointer is built.
module adder_arbiter #(
    parameter int CNT_W = adder_arb_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [1:0]                     req_valid,
    output logic [1:0]                     req_ready,
    input  logic [adder_arb_pkg::WIDTH-1:0] req_a0,
    input  logic [adder_arb_pkg::WIDTH-1:0] req_b0,
    input  logic [adder_arb_pkg::WIDTH-1:0] req_a1,
    input  logic [adder_arb_pkg::WIDTH-1:0] req_b1,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [adder_arb_pkg::WIDTH-1:0] rsp_sum,
    output logic                           rsp_id,
    output logic [CNT_W-1:0]               op_count
);

    import adder_arb_pkg::*;

    state_t           r_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    req_id_t          r_gnt_id;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum;
    req_id_t          r_rsp_id;
    logic [CNT_W-1:0] r_op_count;

    req_id_t          w_gnt;
    logic [1:0]       w_req_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;

`ifdef ADDER_ARB_RR_EN
    req_id_t          r_last;

    // Tie goes to whoever was not granted last; a lone requester wins outright.
    always_comb begin
        if (req_valid == 2'b11)
            w_gnt = ~r_last;
        else
            w_gnt = req_valid[1] & ~req_valid[0];
    end

    // Pointer moves only when a request is actually accepted.
    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (w_accept)
            r_last <= w_gnt;
    end
`else
    // Fixed priority: requester 0 wins whenever it is valid.
    always_comb begin
        w_gnt = ~req_valid[0];
    end
`endif

    // Ready only toward the granted requester, only in IDLE, only if it is valid.
    always_comb begin
        w_req_ready = 2'b00;
        if (r_state == IDLE && req_valid[w_gnt])
            w_req_ready[w_gnt] = 1'b1;
    end

    assign w_accept = |w_req_ready;

    bit_32_adder u_adder (
        .a   (r_op_a),
        .b   (r_op_b),
        .sum (w_sum)
    );

    // Request -> latch operands -> register sum -> hold response until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_gnt_id    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= w_gnt ? req_a1 : req_a0;
                        r_op_b   <= w_gnt ? req_b1 : req_b0;
                        r_gnt_id <= w_gnt;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_rsp_sum   <= w_sum;
                    r_rsp_id    <= r_gnt_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_count != '1)
                            r_op_count <= r_op_count + CNT_W'(1);
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign op_count  = r_op_count;

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `bit_32_adder` instance between two requesters. Each requester presents a 32-bit operand pair with a valid/ready handshake. The block grants one request at a time, feeds the latched operands through the adder and returns the wrapped 32-bit sum on a single tagged response channel with backpressure. It sits between the requesting datapath blocks and the shared adder resource.

## Interface
- `WIDTH`, 32, operand/sum width; fixed by `bit_32_adder`, not overridable.
- `CNT_W`, 16, width of the completed-operation counter.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept; at most one bit high.
- `req_a0`, `req_b0`  in  32 each  requester 0 operands.
- `req_a1`, `req_b1`  in  32 each  requester 1 operands.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_sum`  out  32  `a + b` mod 2^32.
- `rsp_id`  out  1  index of the requester that owns the response.
- `op_count`  out  `CNT_W`  number of completed responses; saturates at all-ones.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - `req_ready` is driven to the granted requester only when that requester's `req_valid` is high.
  - On handshake, latch the operand pair and the grant id, then go to CALC.
  - With no valid request, stay in IDLE and hold `req_ready` = 0.
- CALC:
  - The adder combinationally sums the latched operands.
  - Register the sum into `rsp_sum` and go to RESP.
- RESP:
  - `rsp_valid` = 1; `rsp_sum` and `rsp_id` are stable.
  - On `rsp_valid && rsp_ready`: increment `op_count` (saturating) and go to IDLE.
  - Otherwise hold.
- `req_ready` = 0 in CALC and RESP. Requests are never accepted while an operation is outstanding.
- Arithmetic: 32-bit wrap. Carry-out is discarded; no overflow flag.
- Arbitration (see Configuration) is evaluated only in IDLE.
  - A requester whose `req_valid` drops before grant is simply not served.
  - Operands need to be stable only in the handshake cycle.
- Reset values: state = IDLE, `req_ready` = 0, `rsp_valid` = 0, `rsp_sum` = 0, `rsp_id` = 0, `op_count` = 0, round-robin pointer = "last granted = 1", so requester 0 wins the first tie.
- Reset mid-operation (CALC or RESP): the outstanding operation is dropped, no response is produced and `op_count` is not incremented.

## Timing
- Request handshake in cycle t, then CALC in t+1, then `rsp_valid` = 1 in t+2.
- Minimum latency from accept to response valid: 2 cycles.
- Response handshake in cycle r puts the FSM in IDLE at r+1. The next request can be accepted at r+1.
- Peak throughput is 1 operation per 3 cycles.
- Holding `rsp_ready` low stalls indefinitely with no loss of data.
- All outputs are registered except `req_ready`, which is a combinational function of state, grant and `req_valid`.

## Configuration
- `ADDER_ARB_RR_EN` defined:
  - Round-robin arbitration. On a tie, the requester not granted last wins.
  - The pointer updates only on an accepted request.
- Not defined:
  - Fixed priority; requester 0 always wins a tie.
  - The pointer register is not built.
- With a single active requester, both modes grant it immediately.

## Structure
- Package `adder_arb_pkg` holds:
  - the `WIDTH` and `CNT_W` constants,
  - the FSM state typedef (IDLE/CALC/RESP),
  - the requester-id type.
- One sub-module: the existing `bit_32_adder`, instantiated exactly once with ports (a, b, sum).
- Arbitration logic stays inline; no separate arbiter module.

## Test plan
- Single request: requester 0 sends a=2345, b=12 → `req_ready[0]` in the same cycle, `rsp_valid` 2 cycles later with `rsp_sum`=2357, `rsp_id`=0, `op_count`=1 after handshake.
- Wrap-around: a=b=0xAAAAAAAA → `rsp_sum`=0x55555554. Also a=0, b=0xAAAAAAAA → 0xAAAAAAAA.
- Tie:
  - Both valid continuously with requester 0 = (502, 23) and requester 1 = (1, 1).
  - With `ADDER_ARB_RR_EN`, responses alternate with `rsp_id` 0 (525), 1 (2), 0, 1, …
  - Without it, every response has `rsp_id`=0.
- Backpressure: hold `rsp_ready`=0 for 10 cycles in RESP → `rsp_valid`, `rsp_sum` and `rsp_id` stay constant, `req_ready`=0 throughout, `op_count` unchanged until the handshake.
- Reset mid-operation: assert `rst` in CALC → next cycle IDLE, `rsp_valid`=0, `op_count`=0, and no response is ever produced for that request.
- Counter saturation: with `CNT_W` forced to 2, run 5 operations → `op_count` sticks at 3.
